tmds_rx_decode: RTL and testbench



---
 rtl/tmds_rx_decode.sv | 175 +++++++++++++++++
 tb/tb_tmds_rx_decode.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_rx_decode.sv
// tmds_rx_decode
//   Receive-side TMDS symbol aligner and decoder for one channel.
//   Takes unaligned 10-bit words from a 1:10 deserializer and searches the
//   ten possible bit offsets for TMDS control tokens. After LOCK_COUNT
//   consecutive tokens at one offset it locks. While locked it decodes each
//   10b symbol into an 8-bit pixel byte or a 2-bit control value.
//
// Ports:
//   clk_i     in   1   pixel (parallel-word) clock
//   rst_i     in   1   synchronous active-high reset
//   raw_i     in  10   deserialized word, raw_i[0] received first
//   data_o    out  8   decoded pixel byte, valid when de_o=1
//   ctrl_o    out  2   last decoded control value {C1,C0}
//   de_o      out  1   data_o holds a decoded data symbol this cycle
//   locked_o  out  1   symbol alignment locked
//   offset_o  out  4   current alignment offset, 0..9
module tmds_rx_decode #(
  parameter int LOCK_COUNT = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] raw_i,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o,
  output logic       de_o,
  output logic       locked_o,
  output logic [3:0] offset_o
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_COUNT);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state_q;
  logic [9:0]    prev_q;
  logic [9:0]    sym_q;
  logic [3:0]    offset_q;
  logic [CW-1:0] tok_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          skip_q;
  logic [7:0]    data_q;
  logic [1:0]    ctrl_q;
  logic          de_q;
  logic          locked_q;

  // Alignment window: 10 bits starting at the current offset in the
  // two-word history {newest, previous}.
  logic [19:0] shifted_d;
  logic [9:0]  window_d;
  always_comb begin
    shifted_d = {raw_i, prev_q} >> offset_q;
    window_d  = shifted_d[9:0];
  end

  // Control token classification of the registered symbol.
  logic       is_tok_d;
  logic [1:0] tok_val_d;
  always_comb begin
    is_tok_d  = 1'b1;
    tok_val_d = 2'b00;
    case (sym_q)
      10'h354: tok_val_d = 2'b00;
      10'h0AB: tok_val_d = 2'b01;
      10'h154: tok_val_d = 2'b10;
      10'h2AB: tok_val_d = 2'b11;
      default: is_tok_d  = 1'b0;
    endcase
  end

  // TMDS data decode: undo the optional inversion, then undo the XOR/XNOR
  // transition chain selected by bit 8.
  logic [7:0] d_d;
  logic [7:0] dec_d;
  assign d_d      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
  assign dec_d[0] = d_d[0];
  for (genvar gi = 1; gi < 8; gi++) begin : g_dec
    assign dec_d[gi] = sym_q[8] ? (d_d[gi] ^ d_d[gi-1]) : ~(d_d[gi] ^ d_d[gi-1]);
  end

  // Timeout expiry: only a non-token can expire the counter, so a token in
  // the expiry cycle always wins. The symbol straddling an offset change is
  // not counted at all.
  logic timeout_d;
  assign timeout_d = !is_tok_d && !skip_q && (to_cnt_q == TO_MAX);

  logic [3:0] offset_inc_d;
  assign offset_inc_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SEARCH;
      prev_q    <= '0;
      sym_q     <= '0;
      offset_q  <= '0;
      tok_cnt_q <= '0;
      to_cnt_q  <= '0;
      skip_q    <= 1'b0;
      data_q    <= '0;
      ctrl_q    <= '0;
      de_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      prev_q <= raw_i;
      sym_q  <= window_d;
      skip_q <= 1'b0;

      // Outputs: decode only while locked; the lock-loss edge already
      // shows de_o=0.
      if (state_q == LOCKED && !timeout_d) begin
        if (is_tok_d) begin
          ctrl_q <= tok_val_d;
          de_q   <= 1'b0;
          data_q <= '0;
        end else begin
          data_q <= dec_d;
          de_q   <= 1'b1;
        end
      end else begin
        de_q   <= 1'b0;
        data_q <= '0;
      end

      if (!skip_q) begin
        case (state_q)
          SEARCH: begin
            if (is_tok_d) begin
              to_cnt_q <= '0;
              if (tok_cnt_q == LOCK_MAX - 1'b1) begin
                tok_cnt_q <= LOCK_MAX;
                state_q   <= LOCKED;
                locked_q  <= 1'b1;
              end else begin
                tok_cnt_q <= tok_cnt_q + 1'b1;
              end
            end else if (timeout_d) begin
              offset_q  <= offset_inc_d;
              tok_cnt_q <= '0;
              to_cnt_q  <= '0;
              skip_q    <= 1'b1;
            end else begin
              tok_cnt_q <= '0;
              to_cnt_q  <= to_cnt_q + 1'b1;
            end
          end
          LOCKED: begin
            if (is_tok_d) begin
              to_cnt_q <= '0;
            end else if (timeout_d) begin
              state_q   <= SEARCH;
              locked_q  <= 1'b0;
              offset_q  <= offset_inc_d;
              tok_cnt_q <= '0;
              to_cnt_q  <= '0;
              skip_q    <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign data_o   = data_q;
  assign ctrl_o   = ctrl_q;
  assign de_o     = de_q;
  assign locked_o = locked_q;
  assign offset_o = offset_q;

endmodule

// File: tb/tb_tmds_rx_decode.sv
module tb_tmds_rx_decode;

  localparam int LOCKN = 16;
  localparam int TMO   = 64;

  logic       clk;
  logic       rst;
  logic [9:0] raw;
  logic [7:0] data_o;
  logic [1:0] ctrl_o;
  logic       de_o;
  logic       locked_o;
  logic [3:0] offset_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  tmds_rx_decode #(.LOCK_COUNT(LOCKN), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .raw_i(raw),
    .data_o(data_o), .ctrl_o(ctrl_o), .de_o(de_o),
    .locked_o(locked_o), .offset_o(offset_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int tok_code(input bit [9:0] s);
    bit [9:0] toks [4];
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    for (int i = 0; i < 4; i++) if (s == toks[i]) return i;
    return -1;
  endfunction

  function automatic bit [7:0] ref_decode(input bit [9:0] q);
    bit [7:0] d, o;
    d = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = ((d[i] != d[i-1]) == q[8]);
    return o;
  endfunction

  // stream bits [off+9:off] of the two newest words
  function automatic bit [9:0] win(input bit [9:0] cur, input bit [9:0] prv, input int off);
    bit [19:0] s;
    s = {cur, prv} >> off;
    return s[9:0];
  endfunction

  // Serial token stream whose symbol boundary sits at bit b of each word.
  function automatic bit [9:0] rot(input bit [9:0] t, input int b);
    bit [19:0] x;
    x = {10'b0, t} << b;
    return x[9:0] | x[19:10];
  endfunction

  bit [9:0] m_prev, m_sym;
  int       m_off, m_run, m_quiet;
  bit       m_skip, m_locked, m_de;
  bit [7:0] m_data;
  bit [1:0] m_ctrl;

  always @(posedge clk) begin
    int       tv;
    bit       expire;
    bit [9:0] nsym;
    if (rst) begin
      m_prev = 0; m_sym = 0; m_off = 0; m_run = 0; m_quiet = 0;
      m_skip = 0; m_locked = 0; m_de = 0; m_data = 0; m_ctrl = 0;
    end else begin
      tv     = tok_code(m_sym);
      nsym   = win(raw, m_prev, m_off);
      expire = (tv < 0) && !m_skip && (m_quiet == TMO - 1);
      if (m_locked && !expire) begin
        if (tv >= 0) begin m_ctrl = 2'(tv); m_de = 0; m_data = 0; end
        else begin m_data = ref_decode(m_sym); m_de = 1; end
      end else begin
        m_de = 0; m_data = 0;
      end
      if (m_skip) m_skip = 0;
      else if (tv >= 0) begin
        m_quiet = 0;
        if (!m_locked) begin
          m_run++;
          if (m_run >= LOCKN) m_locked = 1;
        end
      end else if (expire) begin
        m_locked = 0; m_off = (m_off + 1) % 10; m_run = 0; m_quiet = 0; m_skip = 1;
      end else begin
        m_quiet++;
        if (!m_locked) m_run = 0;
      end
      m_prev = raw;
      m_sym  = nsym;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_data",   data_o,   m_data);
      chk("mdl_ctrl",   ctrl_o,   m_ctrl);
      chk("mdl_de",     de_o,     m_de);
      chk("mdl_locked", locked_o, m_locked);
      chk("mdl_offset", offset_o, m_off);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; presents w, crosses one active edge, returns at the
  // following negedge.
  task automatic drive(input bit [9:0] w);
    raw = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_data", data_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_de", de_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_offset", offset_o, 0);
  endtask

  task automatic lock_at(input int b, input string name);
    int n;
    n = 0;
    while (!locked_o && n < 2000) begin
      drive(rot(10'h354, b));
      n++;
    end
    chk(name, locked_o, 1);
    chk({name, "_off"}, offset_o, b);
  endtask

  // Lock timing from reset at offset 0: the 16th token is classified on the
  // 18th edge after the first token word is presented.
  task automatic lock_timing(input string name);
    for (int j = 1; j <= 18; j++) begin
      drive(10'h354);
      if (j == 17) chk({name, "_pre"}, locked_o, 0);
      if (j == 18) chk({name, "_lock"}, locked_o, 1);
    end
  endtask

  typedef struct {
    logic [9:0] raw;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int prev_off;
    int n;
    tbl[0]  = '{10'h100, 1'b1, 8'h00, 2'b00};
    tbl[1]  = '{10'h0FF, 1'b1, 8'hFF, 2'b00};
    tbl[2]  = '{10'h2FF, 1'b1, 8'hFE, 2'b00};
    tbl[3]  = '{10'h354, 1'b0, 8'h00, 2'b00};
    tbl[4]  = '{10'h0AB, 1'b0, 8'h00, 2'b01};
    tbl[5]  = '{10'h154, 1'b0, 8'h00, 2'b10};
    tbl[6]  = '{10'h2AB, 1'b0, 8'h00, 2'b11};
    tbl[7]  = '{10'h300, 1'b1, 8'h01, 2'b11};
    tbl[8]  = '{10'h201, 1'b1, 8'hFC, 2'b11};
    tbl[9]  = '{10'h1AA, 1'b1, 8'hFE, 2'b11};
    tbl[10] = '{10'h155, 1'b1, 8'hFF, 2'b11};

    rst = 1;
    raw = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;

    // Lock at offset 0, then decode table (each word held for 3 edges)
    $display("seq: lock at offset 0 and decode table");
    do_reset();
    lock_timing("t1");
    drive(10'h354);
    drive(10'h354);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].raw);
      drive(tbl[i].raw);
      drive(tbl[i].raw);
      chk($sformatf("tbl%0d_de", i), de_o, tbl[i].de);
      chk($sformatf("tbl%0d_data", i), data_o, tbl[i].data);
      chk($sformatf("tbl%0d_ctrl", i), ctrl_o, tbl[i].ctrl);
      $display("vec %0d raw=%03h de=%0d data=%02h ctrl=%0d", i, tbl[i].raw, de_o, data_o, ctrl_o);
    end

    // Broken token run resets the count
    $display("seq: 10 tokens, 1 data, 16 tokens");
    do_reset();
    for (int j = 1; j <= 29; j++) begin
      drive((j == 11) ? 10'h100 : 10'h354);
      if (j == 28) chk("t3_pre", locked_o, 0);
      if (j == 29) chk("t3_lock", locked_o, 1);
    end
    chk("t3_off", offset_o, 0);

    // Search walks offsets 0->1->2->3
    $display("seq: search to offset 3");
    do_reset();
    prev_off = 0;
    n = 0;
    while (!locked_o && n < 1000) begin
      drive(rot(10'h354, 3));
      if (offset_o != 4'(prev_off)) begin
        chk("t2_step", offset_o, prev_off + 1);
        prev_off = offset_o;
      end
      n++;
    end
    chk("t2_lock", locked_o, 1);
    chk("t2_off", offset_o, 3);
    chk("t2_ctrl", ctrl_o, 0);

    // Lock loss at offset 9 after 64 non-tokens, wraps to 0
    $display("seq: lock loss at offset 9");
    do_reset();
    lock_at(9, "t4_lock");
    for (int j = 1; j <= 65; j++) begin
      drive(10'h100);
      if (j == 64) chk("t4_hold", locked_o, 1);
      if (j == 65) begin
        chk("t4_lost", locked_o, 0);
        chk("t4_wrap", offset_o, 0);
        chk("t4_de", de_o, 0);
      end
    end

    // Token in the last cycle before expiry keeps the lock
    $display("seq: token before expiry");
    do_reset();
    lock_at(9, "t4b_lock");
    for (int j = 1; j <= 63; j++) drive(10'h100);
    for (int j = 0; j < 5; j++) drive(rot(10'h354, 9));
    chk("t4b_held", locked_o, 1);
    chk("t4b_off", offset_o, 9);

    // Reset while locked with data flowing
    $display("seq: reset mid-stream");
    do_reset();
    lock_at(0, "t6_lock");
    for (int j = 0; j < 10; j++) drive(10'($urandom_range(0, 255)) | 10'h100);
    chk("t6_flow", de_o, 1);
    do_reset();
    lock_timing("t6");

    // Randomized: mostly tokens while locked, then pure noise
    $display("seq: random stream");
    do_reset();
    for (int j = 0; j < 30; j++) drive(10'h354);
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0: drive(10'h354);
          1: drive(10'h0AB);
          2: drive(10'h154);
          default: drive(10'h2AB);
        endcase
      end else drive(10'($urandom));
    end
    for (int j = 0; j < 300; j++) drive(10'($urandom));

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
